// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the mmio_timer peripheral: register offsets, bit
// positions and bus FSM states.
package mmio_timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_CLR_ON_MATCH = 1;
    localparam int CTRL_IRQ_EN       = 2;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RD_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/mmio_timer_if.sv
// Data-memory bus seen by the timer peripheral; the core is the master.
interface mmio_timer_if;
    logic        en;
    logic        write_enable;
    logic        byte_enable;
    logic        byte_select;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        serviced_read;
    logic        mem_wait;
    logic        irq;

    modport master (
        output en, write_enable, byte_enable, byte_select, addr, data_in,
        input  data_out, serviced_read, mem_wait, irq
    );

    modport slave (
        input  en, write_enable, byte_enable, byte_select, addr, data_in,
        output data_out, serviced_read, mem_wait, irq
    );
endinterface

// File: rtl/timer_counter.sv
// Prescaler plus 16-bit up-counter with compare-match and overflow events.
module timer_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_on_match,
    input  logic [15:0] prescale,
    input  logic [15:0] compare,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        presc_clr,
    output logic [15:0] count,
    output logic        match_evt,
    output logic        ovf_evt
);
    logic [15:0] presc_q, presc_d;
    logic [15:0] count_q, count_d;
    logic        tick, cmp_hit, clr;

    always_comb begin
        tick      = en & (presc_q == prescale);
        cmp_hit   = (count_q == compare);
        clr       = cmp_hit & clr_on_match;
        presc_d   = presc_q;
        count_d   = count_q;
        match_evt = 1'b0;
        ovf_evt   = 1'b0;
        if (en) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
        if (presc_clr | load) begin
            presc_d = 16'd0;
        end
        // A bus load overrides the tick entirely, including its events.
        if (load) begin
            count_d = load_val;
        end else if (tick) begin
            match_evt = cmp_hit;
            ovf_evt   = (count_q == 16'hFFFF) & ~clr;
            count_d   = clr ? 16'd0 : count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            count_q <= 16'd0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: bus responder (one read wait state), register file,
// and timer_counter. Optional MMIO_TIMER_SNAPSHOT_EN adds a COUNT high-byte shadow.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h7F00,
    parameter logic [15:0] RESET_PRESCALE = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    mmio_timer_if.slave  bus
);
    logic        hit, rd_req, wr_req;
    logic [2:0]  off;
    logic [15:0] bmask, wbits, word_val, rd_val, count, count_wval;
    logic        match_evt, ovf_evt, load_count, clr_presc;

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] compare_q, compare_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] data_out_q, data_out_d;
    logic        serviced_q, serviced_d;
    logic        irq_q, irq_d;
`ifdef MMIO_TIMER_SNAPSHOT_EN
    logic [7:0]  shadow_q, shadow_d;
`endif

    assign hit    = bus.en & (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign off    = bus.addr[2:0];
    assign rd_req = hit & ~bus.write_enable & (state_q == ST_IDLE);
    assign wr_req = hit &  bus.write_enable & (state_q == ST_IDLE);

    // Byte writes replicate data_in[7:0] onto both lanes; bmask picks the lane.
    assign bmask = ~bus.byte_enable ? 16'hFFFF : (bus.byte_select ? 16'hFF00 : 16'h00FF);
    assign wbits = bus.byte_enable ? {2{bus.data_in[7:0]}} : bus.data_in;

    assign load_count = wr_req & (off == OFF_COUNT);
    assign clr_presc  = wr_req & (off == OFF_PRESCALE);
    assign count_wval = (count & ~bmask) | (wbits & bmask);

    timer_counter u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (ctrl_q[CTRL_EN]),
        .clr_on_match (ctrl_q[CTRL_CLR_ON_MATCH]),
        .prescale     (prescale_q),
        .compare      (compare_q),
        .load         (load_count),
        .load_val     (count_wval),
        .presc_clr    (clr_presc),
        .count        (count),
        .match_evt    (match_evt),
        .ovf_evt      (ovf_evt)
    );

    always_comb begin
        case (off)
            OFF_CTRL:     word_val = {13'd0, ctrl_q};
            OFF_PRESCALE: word_val = prescale_q;
            OFF_COUNT:    word_val = count;
            OFF_COMPARE:  word_val = compare_q;
            OFF_STATUS:   word_val = {14'd0, status_q};
            default:      word_val = 16'd0;
        endcase
        rd_val = word_val;
        if (bus.byte_enable) begin
            rd_val = bus.byte_select ? {8'd0, word_val[15:8]} : {8'd0, word_val[7:0]};
        end
`ifdef MMIO_TIMER_SNAPSHOT_EN
        shadow_d = shadow_q;
        if (bus.byte_enable && off == OFF_COUNT) begin
            if (bus.byte_select) begin
                rd_val = {8'd0, shadow_q};
            end else if (rd_req) begin
                shadow_d = count[15:8];
            end
        end
`endif
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        status_d   = status_q;
        if (wr_req) begin
            case (off)
                OFF_CTRL:     ctrl_d     = (ctrl_q & ~bmask[2:0]) | (wbits[2:0] & bmask[2:0]);
                OFF_PRESCALE: prescale_d = (prescale_q & ~bmask) | (wbits & bmask);
                OFF_COMPARE:  compare_d  = (compare_q & ~bmask) | (wbits & bmask);
                OFF_STATUS:   status_d   = status_q & ~(wbits[1:0] & bmask[1:0]);
                default:      ;
            endcase
        end
        // Set events are applied after the W1C so a simultaneous set survives.
        status_d[STAT_MATCH] = status_d[STAT_MATCH] | match_evt;
        status_d[STAT_OVF]   = status_d[STAT_OVF] | ovf_evt;
        irq_d = ctrl_d[CTRL_IRQ_EN] & (|status_d);

        data_out_d = rd_req ? rd_val : data_out_q;
        serviced_d = serviced_q;
        if (bus.en & ~(hit & ~bus.write_enable)) begin
            serviced_d = 1'b0;
        end
        if (rd_req) begin
            serviced_d = 1'b1;
        end
        state_d = rd_req ? ST_RD_ACK : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 3'd0;
            prescale_q <= RESET_PRESCALE;
            compare_q  <= 16'hFFFF;
            status_q   <= 2'd0;
            data_out_q <= 16'd0;
            serviced_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            data_out_q <= data_out_d;
            serviced_q <= serviced_d;
            irq_q      <= irq_d;
        end
    end

`ifdef MMIO_TIMER_SNAPSHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 8'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    // Gated by rst_n so a reset during a read drops the stall at once.
    assign bus.mem_wait      = rst_n & rd_req;
    assign bus.data_out      = data_out_q;
    assign bus.serviced_read = serviced_q;
    assign bus.irq           = irq_q;
endmodule

// File: tb/tb_mmio_timer.sv
// Randomized bench for mmio_timer with a register-level behavioural model.
module tb_mmio_timer;
    localparam logic [15:0] BASE = 16'h7F00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(BASE), .RESET_PRESCALE(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_reg [0:4];   // CTRL, PRESCALE, COUNT, COMPARE, STATUS
    int          m_elapsed;     // enabled cycles since last tick
    logic [15:0] m_dout;
    bit          m_srv, m_ack, m_irq;
    logic [7:0]  m_shadow;

    function automatic logic [15:0] reg_val(input int o);
        return (o <= 4) ? m_reg[o] : 16'h0000;
    endfunction

    task automatic model_step();
        bit          hit, rd, wr, tick;
        int          o, n;
        logic [15:0] v, nw, keep, new_count;
        logic [1:0]  set_bits;
        hit = bus.en && (bus.addr[15:3] == BASE[15:3]);
        o   = int'(bus.addr[2:0]);
        rd  = hit && !bus.write_enable && !m_ack;
        wr  = hit && bus.write_enable && !m_ack;
        if (bus.en && !(hit && !bus.write_enable)) m_srv = 0;
        if (rd) begin
            v = reg_val(o);
            if (bus.byte_enable) v = bus.byte_select ? (v >> 8) : (v & 16'h00FF);
`ifdef MMIO_TIMER_SNAPSHOT_EN
            if (bus.byte_enable && o == 2) begin
                if (bus.byte_select) v = {8'h00, m_shadow};
                else m_shadow = m_reg[2][15:8];
            end
`endif
            m_dout = v;
            m_srv  = 1;
        end
        m_ack = rd;

        set_bits  = 2'b00;
        new_count = m_reg[2];
        tick = m_reg[0][0] && (m_elapsed == int'(m_reg[1]));
        if (m_reg[0][0]) m_elapsed = tick ? 0 : m_elapsed + 1;
        if (tick) begin
            if (m_reg[2] == m_reg[3]) begin
                set_bits[0] = 1'b1;
            end
            if (m_reg[2] == m_reg[3] && m_reg[0][1]) begin
                new_count = 16'h0000;
            end else begin
                n = int'(m_reg[2]) + 1;
                if (n == 65536) begin
                    set_bits[1] = 1'b1;
                    n = 0;
                end
                new_count = 16'(n);
            end
        end

        if (wr) begin
            nw   = bus.byte_enable ? (bus.byte_select ? {bus.data_in[7:0], 8'h00}
                                                      : {8'h00, bus.data_in[7:0]}) : bus.data_in;
            keep = bus.byte_enable ? (bus.byte_select ? 16'h00FF : 16'hFF00) : 16'h0000;
            case (o)
                0: m_reg[0] = ((m_reg[0] & keep) | nw) & 16'h0007;
                1: begin m_reg[1] = (m_reg[1] & keep) | nw; m_elapsed = 0; end
                2: begin new_count = (m_reg[2] & keep) | nw; m_elapsed = 0; set_bits = 2'b00; end
                3: m_reg[3] = (m_reg[3] & keep) | nw;
                4: m_reg[4] = m_reg[4] & ~nw & 16'h0003;
                default: ;
            endcase
        end
        m_reg[2] = new_count;
        m_reg[4] = m_reg[4] | {14'd0, set_bits};
        m_irq = m_reg[0][2] && (m_reg[4] != 16'h0000);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg[0] = 16'h0000; m_reg[1] = 16'h0000; m_reg[2] = 16'h0000;
            m_reg[3] = 16'hFFFF; m_reg[4] = 16'h0000;
            m_elapsed = 0; m_dout = 16'h0000; m_srv = 0; m_ack = 0; m_irq = 0;
            m_shadow = 8'h00;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        bit exp_mw;
        exp_mw = rst_n && bus.en && (bus.addr[15:3] == BASE[15:3]) && !bus.write_enable && !m_ack;
        check("data_out", bus.data_out, m_dout);
        check("serviced_read", {15'd0, bus.serviced_read}, {15'd0, m_srv});
        check("irq", {15'd0, bus.irq}, {15'd0, m_irq});
        check("mem_wait", {15'd0, bus.mem_wait}, {15'd0, exp_mw});
    end

    // ---------------- bus tasks (called at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input bit be, input bit bs);
        bus.en = 1; bus.write_enable = 1; bus.byte_enable = be; bus.byte_select = bs;
        bus.addr = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.en = 0; bus.write_enable = 0;
    endtask

    task automatic bus_read(input logic [15:0] a, input bit be, input bit bs,
                            output logic [15:0] d, output int waits);
        waits = 0;
        bus.en = 1; bus.write_enable = 0; bus.byte_enable = be; bus.byte_select = bs;
        bus.addr = a; bus.data_in = 16'($urandom);
        #1 if (bus.mem_wait) waits++;
        @(posedge clk); #1;
        if (bus.mem_wait) waits++;
        @(posedge clk); #1;
        bus.en = 0;
        d = bus.data_out;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, a;
        int          w, n, r;
        bit          be, bs;
        bus.en = 0; bus.write_enable = 0; bus.byte_enable = 0; bus.byte_select = 0;
        bus.addr = 16'h0000; bus.data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("reset_data_out", bus.data_out, 16'h0000);
        check("reset_serviced", {15'd0, bus.serviced_read}, 16'h0000);
        check("reset_irq", {15'd0, bus.irq}, 16'h0000);
        @(posedge clk); #1;

        bus_read(BASE + 16'd3, 0, 0, d, w);
        check("reset_compare", d, 16'hFFFF);
        check("read_wait_cycles", 16'(w), 16'd1);
        check("read_serviced", {15'd0, bus.serviced_read}, 16'h0001);
        bus_read(BASE + 16'd2, 0, 0, d, w);
        check("reset_count", d, 16'h0000);

        // prescale 2, compare 5, clear-on-match with irq
        bus_write(BASE + 16'd1, 16'd2, 0, 0);
        bus_write(BASE + 16'd3, 16'd5, 0, 0);
        bus_write(BASE + 16'd0, 16'h0007, 0, 0);
        n = 0;
        while (!bus.irq && n < 100) begin @(posedge clk); #1; n++; end
        check("match_irq_latency", 16'(n), 16'd18);
        bus_read(BASE + 16'd2, 0, 0, d, w);
        check("count_after_match", d, 16'h0000);
        bus_read(BASE + 16'd4, 0, 0, d, w);
        check("status_match", d, 16'h0001);

        // overflow without irq enable
        bus_write(BASE + 16'd0, 16'h0000, 0, 0);
        bus_write(BASE + 16'd4, 16'h0003, 0, 0);
        bus_write(BASE + 16'd1, 16'h0000, 0, 0);
        bus_write(BASE + 16'd3, 16'h1234, 0, 0);
        bus_write(BASE + 16'd2, 16'hFFFE, 0, 0);
        bus_write(BASE + 16'd0, 16'h0001, 0, 0);
        idle(2);
        bus_read(BASE + 16'd4, 0, 0, d, w);
        check("status_ovf", d, 16'h0002);
        check("irq_masked", {15'd0, bus.irq}, 16'h0000);
        bus_write(BASE + 16'd4, 16'h0002, 0, 0);
        bus_read(BASE + 16'd4, 0, 0, d, w);
        check("status_w1c", d, 16'h0000);

        // byte lanes
        bus_write(BASE + 16'd3, 16'h0011, 0, 0);
        bus_write(BASE + 16'd3, 16'h55AB, 1, 1);
        bus_read(BASE + 16'd3, 0, 0, d, w);
        check("byte_write_hi", d, 16'hAB11);
        bus_read(BASE + 16'd3, 1, 1, d, w);
        check("byte_read_hi", d, 16'h00AB);
        bus_read(BASE + 16'd3, 1, 0, d, w);
        check("byte_read_lo", d, 16'h0011);

        // out-of-window and reserved offsets
        bus_read(BASE + 16'd8, 0, 0, d, w);
        check("miss_wait_cycles", 16'(w), 16'd0);
        check("miss_serviced", {15'd0, bus.serviced_read}, 16'h0000);
        bus_write(BASE + 16'd6, 16'hBEEF, 0, 0);
        bus_read(BASE + 16'd6, 0, 0, d, w);
        check("reserved_read", d, 16'h0000);
        check("reserved_wait", 16'(w), 16'd1);
        bus_read(BASE + 16'd3, 0, 0, d, w);
        check("compare_unchanged", d, 16'hAB11);

        // high-byte snapshot across a low-byte rollover
        bus_write(BASE + 16'd3, 16'h1234, 0, 0);
        bus_write(BASE + 16'd2, 16'h12FF, 0, 0);
        bus_read(BASE + 16'd2, 1, 0, d, w);
        check("snap_low", d, 16'h00FF);
        bus_read(BASE + 16'd2, 1, 1, d, w);
`ifdef MMIO_TIMER_SNAPSHOT_EN
        check("snap_high", d, 16'h0012);
`else
        check("snap_high", d, 16'h0013);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r  = $urandom_range(0, 9);
            a  = BASE + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 65535));
            be = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            if (r < 4) begin
                d = 16'($urandom);
                if (a == BASE + 16'd1) begin d = 16'($urandom_range(0, 3)); be = 0; end
                if (a == BASE + 16'd3 && $urandom_range(0, 1) == 1) d = 16'($urandom_range(0, 12));
                bus_write(a, d, be, bs);
            end else if (r < 8) begin
                bus_read(a, be, bs, d, w);
            end else begin
                idle($urandom_range(1, 3));
            end
        end

        // reset in the middle of a read
        bus.en = 1; bus.write_enable = 0; bus.byte_enable = 0; bus.byte_select = 0;
        bus.addr = BASE + 16'd3;
        #2 rst_n = 0;
        #1;
        check("rst_mid_read_wait", {15'd0, bus.mem_wait}, 16'h0000);
        check("rst_mid_read_srv", {15'd0, bus.serviced_read}, 16'h0000);
        bus.en = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        bus_read(BASE + 16'd3, 0, 0, d, w);
        check("post_reset_compare", d, 16'hFFFF);
        bus_read(BASE + 16'd1, 0, 0, d, w);
        check("post_reset_prescale", d, 16'h0000);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
